// File: rtl/lcd_bus_pkg.sv
// Shared types for the panel-side 8080-style LCD bus responder.
package lcd_bus_pkg;

  localparam int LCD_DB_W = 18;
  localparam int LCD_EV_W = LCD_DB_W + 1;

  typedef enum logic {
    RD_IDLE,
    RD_DRIVE
  } rd_state_t;

  typedef struct packed {
    logic                rs;
    logic [LCD_DB_W-1:0] data;
  } lcd_evt_t;

endpackage

// File: rtl/lcd_evt_fifo.sv
// Synchronous show-ahead FIFO holding captured host write events.
module lcd_evt_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lcd_bus_responder.sv
// Panel stand-in for the 18-bit 8080 LCD bus: captures host writes into a
// FIFO, answers host reads, and generates FMARK and a static ID pin.
module lcd_bus_responder
  import lcd_bus_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int FRAME_CYCLES = 1000,
  parameter int FMARK_CYCLES = 4,
  parameter int ID_VALUE     = 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                lcd_cs,
  input  logic                lcd_rs,
  input  logic                lcd_wr,
  input  logic                lcd_rd,
  input  logic                lcd_rst,
  input  logic [LCD_DB_W-1:0] lcd_db_in,
  output logic [LCD_DB_W-1:0] lcd_db_out,
  output logic                lcd_db_oe,
  output logic                lcd_fmark,
  output logic                lcd_id,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic                ev_rs,
  output logic [LCD_DB_W-1:0] ev_data,
  input  logic [LCD_DB_W-1:0] rd_data,
  output logic                rd_strobe,
  output logic                ovf,
  input  logic                ovf_clr
);

  // state    | meaning
  // RD_IDLE  | bus released, waiting for a host read strobe
  // RD_DRIVE | responder drives lcd_db_out until RD rises or CS aborts

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_CYCLES);

  logic cs_s1, cs_s2, rs_s1, rs_s2, rst_s1, rst_s2;
  logic wr_s1, wr_s2, wr_s3, rd_s1, rd_s2, rd_s3;
  logic [LCD_DB_W-1:0] db_s1, db_s2;

  logic          panel_rst;
  logic          wr_edge, rd_fall, rd_rise;
  lcd_evt_t      evt_q;
  rd_state_t     rd_state;
  logic [CW-1:0] frame_cnt;

  logic                push, ovf_set;
  logic [LCD_EV_W-1:0] fifo_head;
  logic                fifo_full, fifo_empty;
  logic [AW:0]         fifo_count;

  assign lcd_id = ID_VALUE[0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      {cs_s1, cs_s2}        <= 2'b11;
      {rs_s1, rs_s2}        <= 2'b00;
      {rst_s1, rst_s2}      <= 2'b11;
      {wr_s1, wr_s2, wr_s3} <= 3'b111;
      {rd_s1, rd_s2, rd_s3} <= 3'b111;
      db_s1                 <= '0;
      db_s2                 <= '0;
    end else begin
      cs_s1  <= lcd_cs;
      cs_s2  <= cs_s1;
      rs_s1  <= lcd_rs;
      rs_s2  <= rs_s1;
      rst_s1 <= lcd_rst;
      rst_s2 <= rst_s1;
      wr_s1  <= lcd_wr;
      wr_s2  <= wr_s1;
      wr_s3  <= wr_s2;
      rd_s1  <= lcd_rd;
      rd_s2  <= rd_s1;
      rd_s3  <= rd_s2;
      db_s1  <= lcd_db_in;
      db_s2  <= db_s1;
    end
  end

  // Edge pulses are registered together with the rs/db sample taken at the
  // same instant as the WR rise, so the host may change DB right after WR.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      panel_rst <= 1'b0;
      wr_edge   <= 1'b0;
      rd_fall   <= 1'b0;
      rd_rise   <= 1'b0;
      evt_q     <= '0;
    end else begin
      panel_rst <= ~rst_s2;
      wr_edge   <= wr_s2 & ~wr_s3 & ~cs_s2 & rst_s2;
      rd_fall   <= ~rd_s2 & rd_s3 & ~cs_s2 & rst_s2;
      rd_rise   <= rd_s2 & ~rd_s3 & ~cs_s2 & rst_s2;
      evt_q     <= '{rs: rs_s2, data: db_s2};
    end
  end

  // A read edge in the same cycle wins over a write edge.
  assign push    = wr_edge & ~panel_rst & (rd_state == RD_IDLE) & ~rd_fall;
  assign ovf_set = push & fifo_full;

  lcd_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LCD_EV_W)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (push),
    .push_data (evt_q),
    .pop       (ev_ready & ~fifo_empty),
    .flush     (panel_rst),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ev_valid         = (fifo_count != '0);
  assign {ev_rs, ev_data} = fifo_head;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_state   <= RD_IDLE;
      lcd_db_out <= '0;
      lcd_db_oe  <= 1'b0;
      rd_strobe  <= 1'b0;
    end else begin
      rd_strobe <= 1'b0;
      if (panel_rst) begin
        rd_state  <= RD_IDLE;
        lcd_db_oe <= 1'b0;
      end else begin
        case (rd_state)
          RD_IDLE: begin
            if (rd_fall) begin
              rd_state   <= RD_DRIVE;
              lcd_db_out <= rd_data;
              lcd_db_oe  <= 1'b1;
            end
          end
          RD_DRIVE: begin
            if (cs_s2) begin
              rd_state  <= RD_IDLE;
              lcd_db_oe <= 1'b0;
            end else if (rd_rise) begin
              rd_state  <= RD_IDLE;
              lcd_db_oe <= 1'b0;
              rd_strobe <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ovf <= 1'b0;
    end else if (panel_rst) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frame_cnt <= '0;
      lcd_fmark <= 1'b0;
    end else if (panel_rst) begin
      frame_cnt <= '0;
      lcd_fmark <= 1'b0;
    end else begin
      frame_cnt <= (frame_cnt == CW'(FRAME_CYCLES - 1)) ? '0 : frame_cnt + 1'b1;
      lcd_fmark <= (frame_cnt < CW'(FMARK_CYCLES));
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: queue-based event model, bus timing checks.
module tb_lcd_bus_responder;

  localparam int DEPTH = 16;
  localparam int FRAME = 10;
  localparam int FMARK = 2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst;
  logic [17:0] lcd_db_in, lcd_db_out, ev_data, rd_data;
  logic        lcd_db_oe, lcd_fmark, lcd_id, ev_valid, ev_ready, ev_rs;
  logic        rd_strobe, ovf, ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [18:0] exp_q[$];
  logic [18:0] push_val;
  int          push_due  = 0;
  bit          model_ovf = 1'b0;
  bit          clr_req   = 1'b0;
  bit          coincide  = 1'b0;

  lcd_bus_responder #(
    .DEPTH        (DEPTH),
    .FRAME_CYCLES (FRAME),
    .FMARK_CYCLES (FMARK),
    .ID_VALUE     (1)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .lcd_cs     (lcd_cs),
    .lcd_rs     (lcd_rs),
    .lcd_wr     (lcd_wr),
    .lcd_rd     (lcd_rd),
    .lcd_rst    (lcd_rst),
    .lcd_db_in  (lcd_db_in),
    .lcd_db_out (lcd_db_out),
    .lcd_db_oe  (lcd_db_oe),
    .lcd_fmark  (lcd_fmark),
    .lcd_id     (lcd_id),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_rs      (ev_rs),
    .ev_data    (ev_data),
    .rd_data    (rd_data),
    .rd_strobe  (rd_strobe),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One clock of consumer activity, checked against the event queue model.
  // mode: 0 never ready, 1 random ready, 2 always ready.
  task automatic cycle(input int mode);
    bit rdy, clr, do_push, was_full;
    rdy = 1'b0;
    if (mode == 2) rdy = 1'b1;
    else if (mode == 1) rdy = 1'($urandom_range(0, 1));
    clr = clr_req;
    if (coincide && push_due == 1) begin
      rdy = 1'b1;
      clr = 1'b1;
    end
    ev_ready = rdy;
    ovf_clr  = clr;
    n_checks++;
    if (ev_valid !== (exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL ev_valid: got %b expected %0d", ev_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      if ({ev_rs, ev_data} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL ev_head: got %05h expected %05h", {ev_rs, ev_data}, exp_q[0]);
      end
    end
    n_checks++;
    if (ovf !== model_ovf) begin
      n_fail++;
      $display("FAIL ovf: got %b expected %b", ovf, model_ovf);
    end
    @(posedge clk);
    #1;
    do_push = 1'b0;
    if (push_due > 0) begin
      push_due--;
      do_push = (push_due == 0);
    end
    was_full = (exp_q.size() == DEPTH);
    if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (clr) model_ovf = 1'b0;
    if (do_push) begin
      if (was_full) model_ovf = 1'b1;
      else exp_q.push_back(push_val);
    end
    clr_req  = 1'b0;
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  // Host write: DB/RS set up 4 clk before the WR rise; event expected 4 clk after.
  task automatic host_write(input logic rs, input logic [17:0] data, input int mode);
    lcd_cs    = 1'b0;
    lcd_rs    = rs;
    lcd_db_in = data;
    lcd_wr    = 1'b0;
    repeat (4) cycle(mode);
    lcd_wr   = 1'b1;
    push_val = {rs, data};
    push_due = 4;
    repeat (2) cycle(mode);
  endtask

  task automatic settle(input int mode);
    repeat (6) cycle(mode);
  endtask

  task automatic test_reset;
    lcd_cs = 1'b1; lcd_rs = 1'b0; lcd_wr = 1'b1; lcd_rd = 1'b1; lcd_rst = 1'b1;
    lcd_db_in = '0; ev_ready = 1'b0; rd_data = '0; ovf_clr = 1'b0;
    nrst = 1'b1;
    #3 nrst = 1'b0;
    tick(3);
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid: got %b expected 0", ev_valid); end
    n_checks++; if (ev_rs !== 1'b0) begin n_fail++; $display("FAIL reset_ev_rs: got %b expected 0", ev_rs); end
    n_checks++; if (ev_data !== 18'h0) begin n_fail++; $display("FAIL reset_ev_data: got %05h expected 0", ev_data); end
    n_checks++; if (lcd_db_out !== 18'h0) begin n_fail++; $display("FAIL reset_db_out: got %05h expected 0", lcd_db_out); end
    n_checks++; if (lcd_db_oe !== 1'b0) begin n_fail++; $display("FAIL reset_db_oe: got %b expected 0", lcd_db_oe); end
    n_checks++; if (rd_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_rd_strobe: got %b expected 0", rd_strobe); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_checks++; if (lcd_fmark !== 1'b0) begin n_fail++; $display("FAIL reset_fmark: got %b expected 0", lcd_fmark); end
    n_checks++; if (lcd_id !== 1'b1) begin n_fail++; $display("FAIL reset_id: got %b expected 1", lcd_id); end
    @(negedge clk);
    nrst = 1'b1;
    tick(2);
    n_checks++; if (lcd_id !== 1'b1) begin n_fail++; $display("FAIL run_id: got %b expected 1", lcd_id); end
  endtask

  task automatic test_basic_writes;
    host_write(1'b0, 18'h0002C, 0);
    host_write(1'b1, 18'h3FFFF, 0);
    host_write(1'b1, 18'h00001, 0);
    settle(0);
    repeat (5) cycle(2);
  endtask

  task automatic test_overflow;
    for (int i = 0; i <= DEPTH; i++) host_write(1'($urandom_range(0, 1)), 18'(i), 0);
    settle(0);
    clr_req = 1'b1;
    repeat (2) cycle(0);
    // Full FIFO: drop + set while a pop and an ovf_clr land on the same edge.
    coincide = 1'b1;
    host_write(1'b1, 18'h15555, 0);
    coincide = 1'b0;
    settle(0);
    repeat (DEPTH + 2) cycle(2);
    clr_req = 1'b1;
    repeat (2) cycle(0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 20; i++) host_write(1'($urandom_range(0, 1)), 18'($urandom), 1);
    settle(1);
    repeat (DEPTH + 4) cycle(2);
  endtask

  task automatic test_panel_reset;
    for (int i = 0; i < 3; i++) host_write(1'($urandom_range(0, 1)), 18'($urandom), 0);
    settle(0);
    lcd_rst = 1'b0;
    tick(4);
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL prst_ev_valid: got %b expected 0", ev_valid); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL prst_ovf: got %b expected 0", ovf); end
    lcd_db_in = 18'h2AAAA;
    lcd_wr = 1'b0;
    tick(2);
    lcd_wr = 1'b1;
    tick(2);
    lcd_rst = 1'b1;
    tick(8);
    exp_q.delete();
    model_ovf = 1'b0;
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL prst_wr_dropped: got %b expected 0", ev_valid); end
    repeat (3) cycle(0);
  endtask

  task automatic test_fmark;
    bit exp_fm;
    lcd_rst = 1'b0;
    tick(5);
    lcd_rst = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick(1);
      exp_fm = (k >= 4) && (((k - 4) % FRAME) < FMARK);
      n_checks++;
      if (lcd_fmark !== exp_fm) begin
        n_fail++;
        $display("FAIL fmark k=%0d: got %b expected %b", k, lcd_fmark, exp_fm);
      end
    end
  endtask

  task automatic read_pulse(input logic [17:0] d, input bit wr_during);
    int strobes;
    strobes = 0;
    rd_data = d;
    lcd_cs  = 1'b0;
    lcd_rd  = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (wr_during && k == 1) lcd_wr = 1'b0;
      if (wr_during && k == 2) lcd_wr = 1'b1;
      tick(1);
      n_checks++;
      if (lcd_db_oe !== (k >= 4)) begin n_fail++; $display("FAIL rd_oe_fall k=%0d: got %b expected %0d", k, lcd_db_oe, k >= 4); end
      if (k >= 4) begin
        n_checks++;
        if (lcd_db_out !== d) begin n_fail++; $display("FAIL rd_db_out k=%0d: got %05h expected %05h", k, lcd_db_out, d); end
      end
      if (rd_strobe === 1'b1) strobes++;
    end
    lcd_rd = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      n_checks++;
      if (lcd_db_oe !== (k < 4)) begin n_fail++; $display("FAIL rd_oe_rise k=%0d: got %b expected %0d", k, lcd_db_oe, k < 4); end
      n_checks++;
      if (rd_strobe !== (k == 4)) begin n_fail++; $display("FAIL rd_strobe k=%0d: got %b expected %0d", k, rd_strobe, k == 4); end
      if (rd_strobe === 1'b1) strobes++;
    end
    n_checks++;
    if (lcd_db_out !== d) begin n_fail++; $display("FAIL rd_db_hold: got %05h expected %05h", lcd_db_out, d); end
    n_checks++;
    if (strobes != 1) begin n_fail++; $display("FAIL rd_strobe_count: got %0d expected 1", strobes); end
    if (wr_during) begin
      tick(4);
      n_checks++;
      if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL wr_in_drive: got ev_valid %b expected 0", ev_valid); end
    end
  endtask

  task automatic test_read;
    read_pulse(18'h12345, 1'b0);
    for (int i = 0; i < 4; i++) read_pulse(18'($urandom), i == 0);
  endtask

  task automatic test_read_abort;
    int strobes, waited;
    strobes = 0;
    waited  = 0;
    rd_data = 18'h0BEEF;
    lcd_cs  = 1'b0;
    lcd_rd  = 1'b0;
    tick(5);
    n_checks++;
    if (lcd_db_oe !== 1'b1) begin n_fail++; $display("FAIL abort_oe_on: got %b expected 1", lcd_db_oe); end
    lcd_cs = 1'b1;
    while (lcd_db_oe !== 1'b0 && waited < 8) begin
      tick(1);
      waited++;
      if (rd_strobe === 1'b1) strobes++;
    end
    n_checks++;
    if (lcd_db_oe !== 1'b0) begin n_fail++; $display("FAIL abort_oe_off: got %b expected 0 within 8 clk", lcd_db_oe); end
    lcd_rd = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (rd_strobe === 1'b1) strobes++;
    end
    n_checks++;
    if (strobes != 0) begin n_fail++; $display("FAIL abort_strobe: got %0d pulses expected 0", strobes); end
    lcd_cs = 1'b0;
    tick(4);
  endtask

  task automatic test_rd_wr_collision;
    lcd_cs  = 1'b0;
    lcd_wr  = 1'b0;
    lcd_db_in = 18'h1F0F0;
    tick(4);
    rd_data = 18'h2C3C3;
    lcd_rd  = 1'b0;
    lcd_wr  = 1'b1;
    tick(6);
    n_checks++;
    if (lcd_db_oe !== 1'b1) begin n_fail++; $display("FAIL coll_oe: got %b expected 1", lcd_db_oe); end
    n_checks++;
    if (lcd_db_out !== 18'h2C3C3) begin n_fail++; $display("FAIL coll_db_out: got %05h expected 2c3c3", lcd_db_out); end
    lcd_rd = 1'b1;
    tick(6);
    n_checks++;
    if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL coll_wr_ignored: got ev_valid %b expected 0", ev_valid); end
    n_checks++;
    if (lcd_db_oe !== 1'b0) begin n_fail++; $display("FAIL coll_oe_off: got %b expected 0", lcd_db_oe); end
  endtask

  initial begin
    test_reset();
    test_basic_writes();
    test_overflow();
    test_back_to_back();
    test_panel_reset();
    test_fmark();
    test_read();
    test_read_abort();
    test_rd_wr_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
